// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter sequence monitor.
// The lock FSM states, step classes and the legal-successor rule are defined here.
package johnson_pkg;

  localparam int JC_N = 8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  typedef enum logic [1:0] {
    STEP_SUCC    = 2'd0,
    STEP_STALL   = 2'd1,
    STEP_SKIP    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  // Legal Johnson successor of an N-bit word
  function automatic logic [JC_N-1:0] jc_next(input logic [JC_N-1:0] q);
    return {q[JC_N-2:0], ~q[JC_N-1]};
  endfunction

  function automatic int jc_phase_w(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: maps an N-bit word to {legal, phase}.
// Low half of the cycle is ones filled from the LSB, high half is ones anchored at the MSB.
module johnson_decode #(
  parameter int N  = 8,
  parameter int PW = $clog2(2 * N)
) (
  input  logic [N-1:0]  jc_i,
  output logic          legal_o,
  output logic [PW-1:0] phase_o
);

  localparam logic [N-1:0]  ONE   = N'(1);
  localparam logic [N-1:0]  ZERO  = N'(0);
  localparam logic [PW:0]   TWO_N = (PW+1)'(2 * N);

  logic [PW:0]  ones_s;
  logic [N-1:0] inv_s;

  // Popcount and contiguity test; x & (x+1) == 0 holds only for 2^p - 1
  always_comb begin
    ones_s = '0;
    for (int i = 0; i < N; i++) begin
      ones_s = ones_s + (PW+1)'(jc_i[i]);
    end
    inv_s = ~jc_i;
    if (jc_i[N-1] == 1'b0) begin
      legal_o = ((jc_i & (jc_i + ONE)) == ZERO);
      phase_o = PW'(ones_s);
    end else begin
      legal_o = ((inv_s & (inv_s + ONE)) == ZERO);
      phase_o = PW'(TWO_N - ones_s);
    end
  end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson counter sequence monitor: decodes sampled words, classifies each step
// against the previous legal phase and runs the SEARCH/LOCKED lock machine.
module johnson_seq_monitor
  import johnson_pkg::*;
#(
  parameter int N          = 8,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8,
  localparam int PW        = jc_phase_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N-1:0]     jc_in,
  input  logic             jc_valid,
  output logic [PW-1:0]    phase,
  output logic             illegal,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] rev_cnt
);

  localparam logic [PW-1:0] LAST_PH   = PW'(2 * N - 1);
  localparam logic [PW-1:0] ZERO_PH   = PW'(0);
  localparam logic [3:0]    LOCK_LAST = 4'(LOCK_COUNT - 1);

  lock_state_e      state_q, state_d;
  step_e            step_s;
  logic             legal_s, event_s;
  logic [PW-1:0]    dec_phase_s, succ_s;
  logic             ref_valid_q, ref_valid_d;
  logic [PW-1:0]    ref_q, ref_d;
  logic [3:0]       run_q, run_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             illegal_q, illegal_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] rev_cnt_q, rev_cnt_d;

  johnson_decode #(.N(N), .PW(PW)) u_dec (
    .jc_i    (jc_in),
    .legal_o (legal_s),
    .phase_o (dec_phase_s)
  );

  assign event_s = jc_valid & ena;

  // Step classification; a legal sample with no reference acts as a skip (fresh reference)
  always_comb begin
    succ_s = (ref_q == LAST_PH) ? ZERO_PH : (ref_q + PW'(1));
    step_s = STEP_ILLEGAL;
    if (!legal_s) begin
      step_s = STEP_ILLEGAL;
    end else if (!ref_valid_q) begin
      step_s = STEP_SKIP;
    end else if (dec_phase_s == succ_s) begin
      step_s = STEP_SUCC;
    end else if (dec_phase_s == ref_q) begin
      step_s = STEP_STALL;
    end else begin
      step_s = STEP_SKIP;
    end
  end

  // Lock FSM next-state and registered-output next values
  always_comb begin
    state_d     = state_q;
    ref_valid_d = ref_valid_q;
    ref_d       = ref_q;
    run_d       = run_q;
    phase_d     = phase_q;
    illegal_d   = illegal_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    rev_cnt_d   = rev_cnt_q;
    if (event_s) begin
      illegal_d = ~legal_s;
      if (legal_s) begin
        phase_d = dec_phase_s;
      end else begin
        phase_d = phase_q;
      end
      case (state_q)
        SEARCH: begin
          case (step_s)
            STEP_SUCC: begin
              ref_d = dec_phase_s;
              if (run_q == LOCK_LAST) begin
                state_d = LOCKED;
                run_d   = 4'd0;
              end else begin
                run_d   = run_q + 4'd1;
              end
            end
            STEP_STALL: ;
            STEP_SKIP: begin
              ref_d       = dec_phase_s;
              ref_valid_d = 1'b1;
              run_d       = 4'd0;
            end
            STEP_ILLEGAL: begin
              ref_valid_d = 1'b0;
              run_d       = 4'd0;
            end
            default: state_d = SEARCH;
          endcase
        end
        LOCKED: begin
          case (step_s)
            STEP_SUCC: begin
              ref_d = dec_phase_s;
              if ((ref_q == LAST_PH) && (dec_phase_s == ZERO_PH)) begin
                rev_cnt_d = rev_cnt_q + CNT_W'(1);
              end else begin
                rev_cnt_d = rev_cnt_q;
              end
            end
            STEP_STALL: ;
            STEP_SKIP, STEP_ILLEGAL: begin
              err_pulse_d = 1'b1;
              err_cnt_d   = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : (err_cnt_q + CNT_W'(1));
              state_d     = SEARCH;
              run_d       = 4'd0;
              ref_valid_d = (step_s == STEP_SKIP);
              ref_d       = (step_s == STEP_SKIP) ? dec_phase_s : ref_q;
            end
            default: state_d = SEARCH;
          endcase
        end
        default: state_d = SEARCH;
      endcase
    end else begin
      err_pulse_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      ref_valid_q <= 1'b0;
      ref_q       <= '0;
      run_q       <= 4'd0;
      phase_q     <= '0;
      illegal_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      rev_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ref_valid_q <= ref_valid_d;
      ref_q       <= ref_d;
      run_q       <= run_d;
      phase_q     <= phase_d;
      illegal_q   <= illegal_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      rev_cnt_q   <= rev_cnt_d;
    end
  end

  assign phase     = phase_q;
  assign illegal   = illegal_q;
  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign rev_cnt   = rev_cnt_q;

endmodule
